// File: rtl/enc_pkg.sv
// Shared fixed-point helpers for the enc_* encoder layers.
// Values are signed two's complement; the Q8.8 limits are the defaults.
package enc_pkg;

  localparam int BITSIZE_DEF = 16;
  localparam int FRAC_DEF    = 8;

  localparam logic signed [15:0] Q_MAX = 16'sh7FFF;
  localparam logic signed [15:0] Q_MIN = 16'sh8000;

  typedef enum logic [1:0] {IDLE, MAC, WRITE, DONE} state_t;

  // Clamp a wide signed value into the range of a bits-wide signed word.
  function automatic logic signed [63:0] sat_to(input logic signed [63:0] v, input int bits);
    logic signed [63:0] hi;
    logic signed [63:0] lo;
    hi = (64'sd1 <<< (bits - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (v > hi) return hi;
    if (v < lo) return lo;
    return v;
  endfunction

  // Full-precision product, arithmetic shift (rounds toward -inf), then clamp.
  function automatic logic signed [63:0] sat_mul(input logic signed [31:0] a,
                                                 input logic signed [31:0] b,
                                                 input int frac, input int bits);
    logic signed [63:0] p;
    p = 64'(a) * 64'(b);
    return sat_to(p >>> frac, bits);
  endfunction

  // Saturating sum of two values already within the word range.
  function automatic logic signed [63:0] sat_add(input logic signed [63:0] a,
                                                 input logic signed [63:0] b,
                                                 input int bits);
    return sat_to(a + b, bits);
  endfunction

endpackage

// File: rtl/enc_1_if.sv
// Handshake and data bundle between a requester and the enc_1 layer.
interface enc_1_if #(
  parameter int BITSIZE = 16,
  parameter int N_IN    = 8,
  parameter int N_OUT   = 6
);
  logic                       start;
  logic [BITSIZE*N_IN-1:0]       x;
  logic [BITSIZE*N_OUT*N_IN-1:0] w;
  logic [BITSIZE*N_OUT-1:0]      b;
  logic                       busy;
  logic                       valid;
  logic [BITSIZE*N_OUT-1:0]      y;

  modport master (output start, x, w, b, input busy, valid, y);
  modport slave  (input start, x, w, b, output busy, valid, y);
endinterface

// File: rtl/enc_mac.sv
// Combinational saturating multiply-add: acc_next = sat(acc + sat(a*b >>> FRAC)).
module enc_mac
  import enc_pkg::*;
#(
  parameter int BITSIZE = BITSIZE_DEF,
  parameter int FRAC    = FRAC_DEF
) (
  input  logic signed [BITSIZE-1:0] acc,
  input  logic signed [BITSIZE-1:0] a,
  input  logic signed [BITSIZE-1:0] b,
  output logic signed [BITSIZE-1:0] acc_next
);

  assign acc_next = BITSIZE'(sat_add(64'(acc), sat_mul(32'(a), 32'(b), FRAC, BITSIZE), BITSIZE));

endmodule

// File: rtl/enc_1.sv
// First encoder layer: y[i] = act(b[i] + sum_j w[i][j]*x[j]) using one shared MAC.
// Operands are captured on start so the requester may change them mid-run.
module enc_1
  import enc_pkg::*;
#(
  parameter int BITSIZE  = BITSIZE_DEF,
  parameter int FRAC     = FRAC_DEF,
  parameter int N_IN     = 8,
  parameter int N_OUT    = 6,
  parameter int ACT_RELU = 1
) (
  input logic   clk,
  input logic   reset,
  enc_1_if.slave bus
);

  localparam int JW = (N_IN  > 1) ? $clog2(N_IN)  : 1;
  localparam int IW = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam logic [JW-1:0] J_LAST = JW'(N_IN - 1);
  localparam logic [IW-1:0] I_LAST = IW'(N_OUT - 1);

  state_t                     state;
  logic [JW-1:0]              j;
  logic [IW-1:0]              i;
  logic signed [BITSIZE-1:0]  acc;
  logic signed [BITSIZE-1:0]  acc_next;
  logic signed [BITSIZE-1:0]  x_q    [N_IN];
  logic signed [BITSIZE-1:0]  w_q    [N_OUT][N_IN];
  logic signed [BITSIZE-1:0]  b_q    [N_OUT];
  logic signed [BITSIZE-1:0]  shadow [N_OUT];
  logic [BITSIZE*N_OUT-1:0]   shadow_flat;
  logic [BITSIZE*N_OUT-1:0]   y_q;
  logic                       busy_q;
  logic                       valid_q;
  logic [IW-1:0]              i_inc;

  assign i_inc     = i + 1'b1;
  assign bus.busy  = busy_q;
  assign bus.valid = valid_q;
  assign bus.y     = y_q;

  enc_mac #(.BITSIZE(BITSIZE), .FRAC(FRAC)) u_mac (
    .acc      (acc),
    .a        (x_q[j]),
    .b        (w_q[i][j]),
    .acc_next (acc_next)
  );

  // Pack the per-neuron shadow results into the published vector layout.
  always_comb begin
    shadow_flat = '0;
    for (int k = 0; k < N_OUT; k++) shadow_flat[BITSIZE*k +: BITSIZE] = shadow[k];
  end

  // Operand snapshot taken when a run is accepted; held until the next acceptance.
  always_ff @(posedge clk) begin
    if (state == IDLE && bus.start) begin
      for (int jj = 0; jj < N_IN; jj++) x_q[jj] <= bus.x[BITSIZE*jj +: BITSIZE];
      for (int ii = 0; ii < N_OUT; ii++) begin
        b_q[ii] <= bus.b[BITSIZE*ii +: BITSIZE];
        for (int jj = 0; jj < N_IN; jj++)
          w_q[ii][jj] <= bus.w[BITSIZE*(ii*N_IN + jj) +: BITSIZE];
      end
    end
  end

  // Sequencer: walks i/j through the MAC, parks each neuron in shadow, publishes all at once.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      i       <= '0;
      j       <= '0;
      acc     <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      y_q     <= '0;
      for (int k = 0; k < N_OUT; k++) shadow[k] <= '0;
    end else begin
      valid_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            i      <= '0;
            j      <= '0;
            acc    <= bus.b[BITSIZE-1:0];
            busy_q <= 1'b1;
            state  <= MAC;
          end
        end
        MAC: begin
          acc <= acc_next;
          if (j == J_LAST) state <= WRITE;
          else             j     <= j + 1'b1;
        end
        WRITE: begin
          shadow[i] <= (ACT_RELU != 0 && acc[BITSIZE-1]) ? '0 : acc;
          if (i == I_LAST) begin
            state <= DONE;
          end else begin
            i     <= i_inc;
            j     <= '0;
            acc   <= b_q[i_inc];
            state <= MAC;
          end
        end
        DONE: begin
          y_q     <= shadow_flat;
          valid_q <= 1'b1;
          busy_q  <= 1'b0;
          state   <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
